// File: rtl/sort_arb.sv
// Two-requester front end for a vector sort pipeline.
// Arbitrates issue, tags each vector, routes results back in issue order.
module sort_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req0_val,
  input  logic                          req1_val,
  output logic                          req0_rdy,
  output logic                          req1_rdy,
  input  logic [8*DATA_WIDTH-1:0]       req0_data,
  input  logic [8*DATA_WIDTH-1:0]       req1_data,
  output logic                          pipe_val,
  input  logic                          pipe_rdy,
  output logic [8*DATA_WIDTH-1:0]       pipe_data,
  input  logic                          res_val,
  input  logic [8*DATA_WIDTH-1:0]       res_data,
  output logic                          rsp0_val,
  output logic                          rsp1_val,
  output logic [8*DATA_WIDTH-1:0]       rsp0_data,
  output logic [8*DATA_WIDTH-1:0]       rsp1_data,
  output logic [$clog2(TAG_DEPTH):0]    inflight,
  output logic                          err
);

  localparam int VW = 8*DATA_WIDTH;
  localparam int AW = $clog2(TAG_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(TAG_DEPTH);

  typedef enum logic {OPEN, LOCKED} state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic            r_last;
  logic            r_grant;
  logic            w_grant;
  logic            w_gval;
  logic            w_open;
  logic            w_notfull;
  logic            w_xfer;
  logic            w_pop;
  logic            w_tag;
  logic [TAG_DEPTH-1:0] r_tag;
  logic [AW-1:0]   r_wp;
  logic [AW-1:0]   r_rp;
  logic [AW:0]     r_cnt;
  logic            r_rsp0_val;
  logic            r_rsp1_val;
  logic [VW-1:0]   r_rsp0_data;
  logic [VW-1:0]   r_rsp1_data;
  logic            r_err;

  // Grant selection, handshake and issue path.
  always_comb begin
    w_open    = (r_state == OPEN);
    w_notfull = (r_cnt != FULL);
    pipe_val  = (req0_val | req1_val) & w_notfull;
    w_grant   = 1'b0;
    unique case (1'b1)
      !w_open:                       w_grant = r_grant;
      w_open & req0_val & req1_val:  w_grant = ~r_last;
      w_open & req1_val & !req0_val: w_grant = 1'b1;
      default:                       w_grant = 1'b0;
    endcase
    w_gval    = w_grant ? req1_val : req0_val;
    w_xfer    = pipe_val & pipe_rdy & w_gval;
    req0_rdy  = w_xfer & ~w_grant;
    req1_rdy  = w_xfer & w_grant;
    pipe_data = w_grant ? req1_data : req0_data;
    w_pop     = res_val & (r_cnt != '0);
    w_tag     = r_tag[r_rp];
  end

  // Arbiter next state: lock on stall, unlock on transfer or dropped valid.
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      OPEN:   if (pipe_val & ~pipe_rdy) w_state_nx = LOCKED;
      LOCKED: if (w_xfer | ~w_gval)     w_state_nx = OPEN;
    endcase
  end

  // Arbiter state, frozen grant and round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= OPEN;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      if (w_open) r_grant <= w_grant;
      if (w_xfer) r_last  <= w_grant;
    end
  end

  // Tag FIFO of requester indices and in-flight count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_xfer) begin
        r_tag[r_wp] <= w_grant;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      unique case ({w_xfer, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Result routing pulses and sticky orphan-result flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp0_val  <= 1'b0;
      r_rsp1_val  <= 1'b0;
      r_rsp0_data <= '0;
      r_rsp1_data <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rsp0_val <= w_pop & ~w_tag;
      r_rsp1_val <= w_pop & w_tag;
      if (w_pop & ~w_tag) r_rsp0_data <= res_data;
      if (w_pop & w_tag)  r_rsp1_data <= res_data;
      if (res_val & (r_cnt == '0)) r_err <= 1'b1;
    end
  end

  assign rsp0_val  = r_rsp0_val;
  assign rsp1_val  = r_rsp1_val;
  assign rsp0_data = r_rsp0_data;
  assign rsp1_data = r_rsp1_data;
  assign inflight  = r_cnt;
  assign err       = r_err;

endmodule
